// File: rtl/rx_path_sequencer_if.sv
// Control/status bundle between the LTSSM + PIPE status side (master)
// and the RX path sequencer (slave).
interface rx_path_sequencer_if #(
  parameter int MAXLANES = 16
);
  logic                enable;
  logic [4:0]          numberOfDetectedLanes;
  logic                rateReq;
  logic [2:0]          newGen;
  logic [MAXLANES-1:0] RxValid;
  logic [MAXLANES-1:0] RxElectricalIdle;
  logic [MAXLANES-1:0] PhyStatus;
  logic [2:0]          GEN;
  logic [MAXLANES-1:0] laneMask;
  logic                pathEnable;
  logic                descramblerReset;
  logic                busy;
  logic                rateAck;
  logic                rateError;

  modport master (
    output enable, numberOfDetectedLanes, rateReq, newGen, RxValid, RxElectricalIdle, PhyStatus,
    input  GEN, laneMask, pathEnable, descramblerReset, busy, rateAck, rateError
  );

  modport slave (
    input  enable, numberOfDetectedLanes, rateReq, newGen, RxValid, RxElectricalIdle, PhyStatus,
    output GEN, laneMask, pathEnable, descramblerReset, busy, rateAck, rateError
  );
endinterface

// File: rtl/rx_path_sequencer.sv
// Sequences RX path bring-up, lane-loss recovery and the PHY rate-change
// handshake; every output is a register loaded from the next-state logic.
module rx_path_sequencer #(
  parameter int MAXLANES       = 16,
  parameter int DRAIN_CYCLES   = 4,
  parameter int RESYNC_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                reset,
  rx_path_sequencer_if.slave bus
);
  localparam int            CW          = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RESYNC_LAST = CW'(RESYNC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_VALID = 3'd1,
    S_RESYNC     = 3'd2,
    S_ACTIVE     = 3'd3,
    S_DRAIN      = 3'd4,
    S_PHY_WAIT   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          gen_q, gen_d;
  logic [2:0]          pend_gen_q, pend_gen_d;
  logic                pend_q, pend_d;
  logic [MAXLANES-1:0] phy_seen_q, phy_seen_d;
  logic [MAXLANES-1:0] mask_q, mask_d;
  logic                path_en_q, busy_q;
  logic                dsc_rst_q, dsc_rst_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                all_valid_s;

  // An empty mask never counts as ready, so a link with no lanes times out.
  function automatic logic lanes_ready(input logic [MAXLANES-1:0] mask,
                                       input logic [MAXLANES-1:0] rxv,
                                       input logic [MAXLANES-1:0] eidle);
    return (mask != {MAXLANES{1'b0}}) && ((rxv & mask) == mask) &&
           ((eidle & mask) == {MAXLANES{1'b0}});
  endfunction

  assign all_valid_s = lanes_ready(mask_q, bus.RxValid, bus.RxElectricalIdle);

  always_comb begin
    mask_d = {MAXLANES{1'b0}};
    for (int i = 0; i < MAXLANES; i++) begin
      mask_d[i] = (i < int'(bus.numberOfDetectedLanes));
    end
  end

  always_comb begin
    state_d    = state_q;
    gen_d      = gen_q;
    pend_gen_d = pend_gen_q;
    pend_d     = pend_q;
    phy_seen_d = phy_seen_q;
    dsc_rst_d  = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_VALID;
        S_WAIT_VALID: begin
          if (all_valid_s) begin
            state_d   = S_RESYNC;
            dsc_rst_d = 1'b1;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            pend_d  = 1'b0;
          end else begin
            state_d = S_WAIT_VALID;
          end
        end
        S_RESYNC: begin
          if (!all_valid_s) begin
            state_d = S_WAIT_VALID;
          end else if (cnt_q == RESYNC_LAST) begin
            state_d = S_ACTIVE;
            ack_d   = pend_q;
            pend_d  = 1'b0;
          end else begin
            state_d = S_RESYNC;
          end
        end
        S_ACTIVE: begin
          // Lane loss outranks a same-cycle rate request, which is dropped.
          if (!all_valid_s) begin
            state_d = S_WAIT_VALID;
          end else if (bus.rateReq && (bus.newGen != gen_q)) begin
            state_d    = S_DRAIN;
            pend_gen_d = bus.newGen;
          end else if (bus.rateReq) begin
            ack_d = 1'b1;
          end else begin
            state_d = S_ACTIVE;
          end
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_d    = S_PHY_WAIT;
            gen_d      = pend_gen_q;
            phy_seen_d = {MAXLANES{1'b0}};
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_PHY_WAIT: begin
          phy_seen_d = phy_seen_q | (bus.PhyStatus & mask_q);
          if (phy_seen_d == mask_q) begin
            state_d = S_WAIT_VALID;
            pend_d  = 1'b1;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_PHY_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d != state_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      gen_q      <= 3'd1;
      pend_gen_q <= 3'd0;
      pend_q     <= 1'b0;
      phy_seen_q <= {MAXLANES{1'b0}};
      mask_q     <= {MAXLANES{1'b0}};
      path_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      dsc_rst_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gen_q      <= gen_d;
      pend_gen_q <= pend_gen_d;
      pend_q     <= pend_d;
      phy_seen_q <= phy_seen_d;
      mask_q     <= mask_d;
      path_en_q  <= (state_d == S_ACTIVE);
      busy_q     <= (state_d == S_DRAIN) || (state_d == S_PHY_WAIT) || (state_d == S_RESYNC);
      dsc_rst_q  <= dsc_rst_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign bus.GEN              = gen_q;
  assign bus.laneMask         = mask_q;
  assign bus.pathEnable       = path_en_q;
  assign bus.descramblerReset = dsc_rst_q;
  assign bus.busy             = busy_q;
  assign bus.rateAck          = ack_q;
  assign bus.rateError        = err_q;
endmodule

// File: tb/tb_rx_path_sequencer.sv
// Directed bench for rx_path_sequencer: a vector table for bring-up, rate
// change and lane loss, plus hand sequences for timeouts, enable drop and reset.
module tb_rx_path_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rx_path_sequencer_if #(.MAXLANES(16)) bus ();

  rx_path_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          reps;
    logic        en;
    logic [4:0]  nl;
    logic [15:0] rxv;
    logic [15:0] eid;
    logic [15:0] phy;
    logic        rr;
    logic [2:0]  ng;
    logic        pe;
    logic        dsc;
    logic        busy;
    logic        ack;
    logic        err;
    logic [2:0]  gen;
    logic [15:0] mask;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bring_up(input string name);
    bit ok;
    ok = 1'b0;
    bus.enable = 1'b1; bus.numberOfDetectedLanes = 5'd2;
    bus.RxValid = 16'h0003; bus.RxElectricalIdle = 16'h0000; bus.rateReq = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.pathEnable === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    bit pe_seen;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.enable = 1'b0; bus.numberOfDetectedLanes = 5'd2; bus.rateReq = 1'b0; bus.newGen = 3'd1;
    bus.RxValid = 16'h0000; bus.RxElectricalIdle = 16'h0000; bus.PhyStatus = 16'h0000;

    //            reps en  nl    rxv      eid      phy      rr   ng    pe   dsc  busy ack  err  gen   mask
    vq.push_back('{1, 1'b0, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h3});
    vq.push_back('{7, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 16'h3});
    // rate change 1 -> 3, lane1 reports PhyStatus five cycles after lane0
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h3});
    vq.push_back('{3, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{4, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h2, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{7, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h3});
    // same-rate request acks immediately
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h3});
    // electrical idle on lane1
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h2, 16'h0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{3, 1'b1, 5'd2, 16'h3, 16'h2, 16'h0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{7, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h3});
    // lane loss together with rateReq; then rateReq outside ACTIVE is ignored
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h1, 16'h0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{1, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{7, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h3});
    vq.push_back('{3, 1'b1, 5'd2, 16'h3, 16'h0, 16'h0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h3});

    step();
    chk("rst.pe", 32'(bus.pathEnable), 32'd0);
    chk("rst.gen", 32'(bus.GEN), 32'd1);
    chk("rst.mask", 32'(bus.laneMask), 32'd0);
    chk("rst.pulses", {29'd0, bus.descramblerReset, bus.rateAck, bus.rateError}, 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      for (int r = 0; r < vq[i].reps; r++) begin
        bus.enable = vq[i].en; bus.numberOfDetectedLanes = vq[i].nl;
        bus.RxValid = vq[i].rxv; bus.RxElectricalIdle = vq[i].eid; bus.PhyStatus = vq[i].phy;
        bus.rateReq = vq[i].rr; bus.newGen = vq[i].ng;
        step();
        chk($sformatf("v%0d.%0d.pe", i, r), 32'(bus.pathEnable), 32'(vq[i].pe));
        chk($sformatf("v%0d.%0d.dsc", i, r), 32'(bus.descramblerReset), 32'(vq[i].dsc));
        chk($sformatf("v%0d.%0d.busy", i, r), 32'(bus.busy), 32'(vq[i].busy));
        chk($sformatf("v%0d.%0d.ack", i, r), 32'(bus.rateAck), 32'(vq[i].ack));
        chk($sformatf("v%0d.%0d.err", i, r), 32'(bus.rateError), 32'(vq[i].err));
        chk($sformatf("v%0d.%0d.gen", i, r), 32'(bus.GEN), 32'(vq[i].gen));
        chk($sformatf("v%0d.%0d.mask", i, r), 32'(bus.laneMask), 32'(vq[i].mask));
      end
    end

    // PHY_WAIT timeout: lane1 never reports PhyStatus
    bus.rateReq = 1'b1; bus.newGen = 3'd4;
    step();
    bus.rateReq = 1'b0; bus.PhyStatus = 16'h0001;
    n = 0;
    while (bus.GEN !== 3'd4 && n < 10) begin
      step();
      n++;
    end
    chk("phyto.gen_applied", 32'(bus.GEN), 32'd4);
    n = 0;
    pe_seen = 1'b0;
    while (bus.rateError !== 1'b1 && n < 1100) begin
      step();
      n++;
      if (bus.pathEnable === 1'b1) pe_seen = 1'b1;
    end
    chk("phyto.cycles", 32'(n), 32'd1024);
    chk("phyto.gen_kept", 32'(bus.GEN), 32'd4);
    chk("phyto.pe", 32'(pe_seen), 32'd0);
    chk("phyto.busy", 32'(bus.busy), 32'd0);
    bus.PhyStatus = 16'h0000; bus.enable = 1'b0;
    step();
    chk("phyto.err_pulse", 32'(bus.rateError), 32'd0);

    // laneMask clamp and empty-mask WAIT_VALID timeout
    bus.numberOfDetectedLanes = 5'd20;
    step();
    chk("mask.clamp20", 32'(bus.laneMask), 32'h0000_ffff);
    bus.numberOfDetectedLanes = 5'd16;
    step();
    chk("mask.16", 32'(bus.laneMask), 32'h0000_ffff);
    bus.numberOfDetectedLanes = 5'd0; bus.RxValid = 16'hffff;
    step();
    chk("mask.0", 32'(bus.laneMask), 32'd0);
    bus.enable = 1'b1;
    step();
    n = 0;
    pe_seen = 1'b0;
    while (bus.rateError !== 1'b1 && n < 1100) begin
      step();
      n++;
      if (bus.pathEnable === 1'b1 || bus.descramblerReset === 1'b1) pe_seen = 1'b1;
    end
    chk("wvto.cycles", 32'(n), 32'd1024);
    chk("wvto.never_enabled", 32'(pe_seen), 32'd0);

    // enable dropped in DRAIN: no ack, GEN retained
    bus.enable = 1'b0;
    step();
    bring_up("drain.bring_up");
    bus.rateReq = 1'b1; bus.newGen = 3'd2;
    step();
    chk("drain.busy", 32'(bus.busy), 32'd1);
    bus.rateReq = 1'b0; bus.enable = 1'b0;
    step();
    chk("drain.busy_off", 32'(bus.busy), 32'd0);
    chk("drain.pe", 32'(bus.pathEnable), 32'd0);
    chk("drain.ack", 32'(bus.rateAck), 32'd0);
    step();
    chk("drain.gen_kept", 32'(bus.GEN), 32'd4);
    bring_up("drain.rebring");
    chk("drain.no_late_ack", 32'(bus.rateAck), 32'd0);
    chk("drain.gen_after", 32'(bus.GEN), 32'd4);

    // asynchronous reset while in PHY_WAIT
    bus.rateReq = 1'b1; bus.newGen = 3'd5;
    step();
    bus.rateReq = 1'b0;
    n = 0;
    while (bus.GEN !== 3'd5 && n < 10) begin
      step();
      n++;
    end
    chk("arst.phy_wait", {30'd0, bus.busy, (bus.GEN == 3'd5)}, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst.gen", 32'(bus.GEN), 32'd1);
    chk("arst.mask", 32'(bus.laneMask), 32'd0);
    chk("arst.outs", {27'd0, bus.pathEnable, bus.busy, bus.descramblerReset, bus.rateAck, bus.rateError}, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("arst.after_ack", 32'(bus.rateAck), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
